// File: rtl/trade_report_tx_if.sv
// +----------------------------------------------------------------------------+
// | trade_report_tx_if                                                         |
// | Trade strobe/record inputs and serial/status outputs of trade_report_tx.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface trade_report_tx_if;
  logic       match_signal;
  logic [7:0] trade_price;
  logic [7:0] best_bid;
  logic [7:0] best_ask;
  logic       uart_tx;
  logic       tx_busy;
  logic       overflow;
  logic [7:0] drop_count;

  // master: the trade source; slave: the transmitter
  modport master (
    output match_signal, trade_price, best_bid, best_ask,
    input  uart_tx, tx_busy, overflow, drop_count
  );

  modport slave (
    input  match_signal, trade_price, best_bid, best_ask,
    output uart_tx, tx_busy, overflow, drop_count
  );
endinterface

`default_nettype wire

// File: rtl/trade_report_tx.sv
// +----------------------------------------------------------------------------+
// | trade_report_tx                                                            |
// | Queues trade records and sends each as an 8N1 packet: A5, price, bid, ask, |
// | plus an XOR checksum byte when TRADE_TX_CHECKSUM_EN is defined.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module trade_report_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_50,
  input  logic              reset_n,
  trade_report_tx_if.slave  bus
);

  localparam int c_CPB   = CLK_HZ / BAUD;
  localparam int c_CNT_W = (c_CPB > 1) ? $clog2(c_CPB) : 1;
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_CPB - 1);
  localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE   = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]   c_FULL      = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]         c_SYNC      = 8'hA5;
`ifdef TRADE_TX_CHECKSUM_EN
  localparam logic [2:0]         c_LAST_BYTE = 3'd4;
`else
  localparam logic [2:0]         c_LAST_BYTE = 3'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_baud_cnt, w_baud_nxt;
  logic [2:0]           r_bit_cnt, w_bit_nxt;
  logic [2:0]           r_byte_idx, w_byte_nxt;
  logic                 r_tx, w_tx_nxt;
  logic [23:0]          r_pkt;
  logic [7:0]           w_cur_byte;
  logic                 w_bit_end;
  logic [2:0]           w_bit_inc;

  logic [23:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic                 w_full, w_empty, w_push, w_pop, w_drop;
  logic                 r_overflow;
  logic [7:0]           r_drop_count;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_push    = bus.match_signal && (!w_full || w_pop);
  assign w_drop    = bus.match_signal && w_full && !w_pop;
  assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);
  assign w_bit_inc = r_bit_cnt + 3'd1;

`ifdef TRADE_TX_CHECKSUM_EN
  logic [7:0] w_cksum;
  assign w_cksum = c_SYNC ^ r_pkt[23:16] ^ r_pkt[15:8] ^ r_pkt[7:0];
`endif

  always_comb begin
    w_cur_byte = c_SYNC;
    case (r_byte_idx)
      3'd1:    w_cur_byte = r_pkt[23:16];
      3'd2:    w_cur_byte = r_pkt[15:8];
      3'd3:    w_cur_byte = r_pkt[7:0];
`ifdef TRADE_TX_CHECKSUM_EN
      3'd4:    w_cur_byte = w_cksum;
`endif
      default: w_cur_byte = c_SYNC;
    endcase
  end

  // Next line level is computed with the next state so uart_tx is a clean flop
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = '0;
    w_bit_nxt   = r_bit_cnt;
    w_byte_nxt  = r_byte_idx;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_byte_nxt  = '0;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = w_cur_byte[0];
        end else begin
          w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_tx_nxt  = w_cur_byte[w_bit_inc];
          end
        end else begin
          w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_NEXT;
          w_tx_nxt    = 1'b1;
        end else begin
          w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_NEXT: begin
        w_tx_nxt = 1'b1;
        if (r_byte_idx == c_LAST_BYTE) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_byte_nxt  = r_byte_idx + 3'd1;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_pkt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_tx       <= w_tx_nxt;
      if (w_pop) begin
        r_pkt <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.trade_price, bus.best_bid, bus.best_ask};
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign bus.uart_tx    = r_tx;
  assign bus.tx_busy    = (r_state != S_IDLE);
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_trade_report_tx.sv
// +----------------------------------------------------------------------------+
// | tb_trade_report_tx                                                         |
// | Directed bench for trade_report_tx at CPB=10; honours TRADE_TX_CHECKSUM_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_trade_report_tx;
  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB + 1;
`ifdef TRADE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  trade_report_tx_if bus();

  trade_report_tx #(
    .CLK_HZ    (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_50 (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] p, input logic [7:0] b, input logic [7:0] a);
    bus.match_signal = 1'b1;
    bus.trade_price  = p;
    bus.best_bid     = b;
    bus.best_ask     = a;
    sync();
    bus.match_signal = 1'b0;
  endtask

  task automatic do_reset;
    bus.match_signal = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.tx_busy === 1'b0) break;
    end
    repeat (3) @(negedge clk);
  endtask

  // Captures one 8N1 byte sampled mid-bit; st is the cycle the start bit began
  task automatic recv_byte(output logic [7:0] d, output int st, output logic stop_lvl);
    d = 'x;
    st = -1;
    stop_lvl = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.uart_tx === 1'b0) begin
        st = cyc;
        break;
      end
    end
    if (st < 0) return;
    repeat (CPB / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      d[k] = bus.uart_tx;
    end
    repeat (CPB) @(negedge clk);
    stop_lvl = bus.uart_tx;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    int st, p;
    logic sl;
    bus.match_signal = 1'b0;
    bus.trade_price = '0;
    bus.best_bid = '0;
    bus.best_ask = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.uart_tx); else n_pass++;
    n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.tx_busy); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'h00) $display("FAIL reset_drop: got %h want 00", bus.drop_count); else n_pass++;
    // release and strobe together: first edge with reset_n=1 must take the push
    @(negedge clk);
    rst_n = 1'b1;
    bus.match_signal = 1'b1;
    bus.trade_price = 8'h11;
    bus.best_bid = 8'h22;
    bus.best_ask = 8'h33;
    sync();
    p = cyc;
    bus.match_signal = 1'b0;
    recv_byte(d, st, sl);
    n_checks++; if (st !== p + 1) $display("FAIL first_push_start: got %0d want %0d", st, p + 1); else n_pass++;
    n_checks++; if (d !== 8'hA5) $display("FAIL first_push_sync: got %h want a5", d); else n_pass++;
    for (int j = 1; j < NB; j++) recv_byte(d, st, sl);
    wait_idle();
  endtask

  task automatic test_single_trade;
    logic [7:0] exp_b [5];
    logic [7:0] d;
    int st, prev, n;
    logic sl;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h37; exp_b[2] = 8'h38; exp_b[3] = 8'h36; exp_b[4] = 8'h9C;
    wait_idle();
    sync();
    n = cyc;
    pulse(8'h37, 8'h38, 8'h36);
    prev = 0;
    for (int j = 0; j < NB; j++) begin
      recv_byte(d, st, sl);
      n_checks++; if (d !== exp_b[j]) $display("FAIL single_byte%0d: got %h want %h", j, d, exp_b[j]); else n_pass++;
      n_checks++; if (sl !== 1'b1) $display("FAIL single_stop%0d: got %b want 1", j, sl); else n_pass++;
      if (j == 0) begin
        n_checks++; if (st !== n + 2) $display("FAIL single_latency: got %0d want %0d", st, n + 2); else n_pass++;
      end else begin
        n_checks++; if (st - prev !== FRAME) $display("FAIL single_spacing%0d: got %0d want %0d", j, st - prev, FRAME); else n_pass++;
      end
      prev = st;
    end
    wait_idle();
  endtask

  task automatic test_busy_length;
    int cnt;
    sync();
    pulse(8'h37, 8'h38, 8'h36);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.tx_busy === 1'b1) cnt++;
      else if (cnt > 0) break;
    end
    n_checks++; if (cnt !== NB * FRAME) $display("FAIL busy_cycles: got %0d want %0d", cnt, NB * FRAME); else n_pass++;
    n_checks++; if (bus.uart_tx !== 1'b1) $display("FAIL idle_tx: got %b want 1", bus.uart_tx); else n_pass++;
  endtask

  task automatic test_overflow;
    logic [7:0] got [25];
    logic [7:0] e;
    logic [7:0] d;
    int st, lows;
    logic sl;
    do_reset();
    sync();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus.match_signal = 1'b1;
          bus.trade_price = 8'h10 + 8'(i);
          bus.best_bid = 8'h20 + 8'(i);
          bus.best_ask = 8'h30 + 8'(i);
          sync();
        end
        bus.match_signal = 1'b0;
      end
      begin
        for (int k = 0; k < 5 * NB; k++) begin
          recv_byte(d, st, sl);
          got[k] = d;
        end
      end
    join
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < NB; j++) begin
        case (j)
          0: e = 8'hA5;
          1: e = 8'h10 + 8'(p);
          2: e = 8'h20 + 8'(p);
          3: e = 8'h30 + 8'(p);
          default: e = 8'hA5 ^ (8'h10 + 8'(p)) ^ (8'h20 + 8'(p)) ^ (8'h30 + 8'(p));
        endcase
        n_checks++; if (got[p * NB + j] !== e) $display("FAIL ovf_pkt%0d_byte%0d: got %h want %h", p, j, got[p * NB + j], e); else n_pass++;
      end
    end
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'd1) $display("FAIL ovf_drop: got %h want 01", bus.drop_count); else n_pass++;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.uart_tx !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) $display("FAIL ovf_no_sixth: got %0d low samples want 0", lows); else n_pass++;
  endtask

  task automatic test_back_to_back(input int off);
    logic [7:0] got [10];
    int sts [10];
    logic [7:0] d;
    int st, n, s_last;
    logic sl;
    wait_idle();
    sync();
    n = cyc;
    s_last = n + 2 + (NB - 1) * FRAME;
    fork
      begin
        pulse(8'h01, 8'h02, 8'h03);
        while (cyc != s_last + off) sync();
        pulse(8'h5A, 8'h6B, 8'h7C);
      end
      begin
        for (int k = 0; k < 2 * NB; k++) begin
          recv_byte(d, st, sl);
          got[k] = d;
          sts[k] = st;
        end
      end
    join
    n_checks++; if (sts[NB - 1] !== s_last) $display("FAIL b2b%0d_last_start: got %0d want %0d", off, sts[NB - 1], s_last); else n_pass++;
    n_checks++; if (sts[NB] !== s_last + FRAME + 1) $display("FAIL b2b%0d_next_start: got %0d want %0d", off, sts[NB], s_last + FRAME + 1); else n_pass++;
    n_checks++; if (got[NB] !== 8'hA5) $display("FAIL b2b%0d_sync: got %h want a5", off, got[NB]); else n_pass++;
    n_checks++; if (got[NB + 1] !== 8'h5A) $display("FAIL b2b%0d_price: got %h want 5a", off, got[NB + 1]); else n_pass++;
    n_checks++; if (got[NB + 3] !== 8'h7C) $display("FAIL b2b%0d_ask: got %h want 7c", off, got[NB + 3]); else n_pass++;
    n_checks++; if (got[3] !== 8'h03) $display("FAIL b2b%0d_first_ask: got %h want 03", off, got[3]); else n_pass++;
  endtask

  task automatic test_reset_mid_data;
    int n, lows, busy;
    wait_idle();
    sync();
    n = cyc;
    pulse(8'h44, 8'h55, 8'h66);
    pulse(8'h45, 8'h56, 8'h67);
    pulse(8'h46, 8'h57, 8'h68);
    // bit 1 of the A5 sync byte is a 0, so the line is low here
    while (cyc != n + 2 + 2 * CPB + 5) sync();
    n_checks++; if (bus.uart_tx !== 1'b0) $display("FAIL mid_data_low: got %b want 0", bus.uart_tx); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.uart_tx !== 1'b1) $display("FAIL abort_tx: got %b want 1", bus.uart_tx); else n_pass++;
    n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.tx_busy); else n_pass++;
    sync();
    rst_n = 1'b1;
    lows = 0;
    busy = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.uart_tx !== 1'b1) lows++;
      if (bus.tx_busy !== 1'b0) busy++;
    end
    n_checks++; if (lows !== 0) $display("FAIL abort_no_frames: got %0d low samples want 0", lows); else n_pass++;
    n_checks++; if (busy !== 0) $display("FAIL abort_queue_flushed: got %0d busy samples want 0", busy); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'h00) $display("FAIL abort_drop: got %h want 00", bus.drop_count); else n_pass++;
  endtask

  task automatic test_saturation;
    do_reset();
    sync();
    bus.match_signal = 1'b1;
    bus.trade_price = 8'h99;
    bus.best_bid = 8'h98;
    bus.best_ask = 8'h9A;
    repeat (205) @(posedge clk);
    #1;
    n_checks++; if (bus.drop_count !== 8'd200) $display("FAIL sat_mid: got %0d want 200", bus.drop_count); else n_pass++;
    repeat (100) @(posedge clk);
    #1;
    bus.match_signal = 1'b0;
    n_checks++; if (bus.drop_count !== 8'hFF) $display("FAIL sat_cap: got %h want ff", bus.drop_count); else n_pass++;
    repeat (500) @(posedge clk);
    #1;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL sat_sticky: got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'hFF) $display("FAIL sat_hold: got %h want ff", bus.drop_count); else n_pass++;
    do_reset();
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL sat_clear_ovf: got %b want 0", bus.overflow); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'h00) $display("FAIL sat_clear_drop: got %h want 00", bus.drop_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_trade();
    test_busy_length();
    test_overflow();
    test_back_to_back(95);
    test_back_to_back(100);
    test_reset_mid_data();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
